// File: rtl/bist_lfsr_misr_if.sv
// Interface bundling the control inputs and status outputs of the BIST LFSR/MISR.
// The count width is derived from NUM_PATTERNS exactly as the core derives it.
interface bist_lfsr_misr_if #(
    parameter int WIDTH        = 8,
    parameter int NUM_PATTERNS = 255
);
    localparam int CNT_W = $clog2(NUM_PATTERNS + 1);

    logic             start;
    logic             mode;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             lockup;

    modport master (
        output start, mode, seed_load, seed_in, data_in, data_valid,
        input  q, busy, done, count, lockup
    );

    modport slave (
        input  start, mode, seed_load, seed_in, data_in, data_valid,
        output q, busy, done, count, lockup
    );
endinterface

// File: rtl/bist_lfsr_misr.sv
// BIST pattern generator / signature compactor sharing one shift register.
// Fibonacci-style LFSR: fb = ^(q & TAPS), q <= {q[WIDTH-2:0], fb}; in MISR
// mode the shifted value is XORed with the response word.
// Optional build macro BIST_LFSR_LOCKUP_RECOVER_EN: a PRPG advance from the
// all-zero state reloads SEED and raises a sticky lockup flag.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | q/count hold; accepts seed_load and start
//   RUN    | advancing (every cycle in PRPG, on data_valid in MISR)
//   DONE   | one-cycle completion pulse, then back to IDLE
module bist_lfsr_misr #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED         = WIDTH'(8'h01),
    parameter int               NUM_PATTERNS = 255
) (
    input  logic              clk,
    input  logic              rst,
    bist_lfsr_misr_if.slave   bus
);
    localparam int               CNT_W = $clog2(NUM_PATTERNS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_PATTERNS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_r, q_d;
    logic [CNT_W-1:0] count_r, count_d;
    logic             mode_r, mode_d;
    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic             advance;
`ifdef BIST_LFSR_LOCKUP_RECOVER_EN
    logic             lockup_r, lockup_d;
`endif

    // State, register and counter update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            q_r      <= SEED;
            count_r  <= '0;
            mode_r   <= 1'b0;
`ifdef BIST_LFSR_LOCKUP_RECOVER_EN
            lockup_r <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            q_r      <= q_d;
            count_r  <= count_d;
            mode_r   <= mode_d;
`ifdef BIST_LFSR_LOCKUP_RECOVER_EN
            lockup_r <= lockup_d;
`endif
        end
    end

    // Next-state logic: sequencing, seed load and register advance
    always_comb begin
        state_d  = state_q;
        q_d      = q_r;
        count_d  = count_r;
        mode_d   = mode_r;
`ifdef BIST_LFSR_LOCKUP_RECOVER_EN
        lockup_d = lockup_r;
`endif
        fb       = ^(q_r & TAPS);
        shifted  = {q_r[WIDTH-2:0], fb};
        advance  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Loading together with start makes the run begin from seed_in
                if (bus.seed_load) begin
                    q_d = bus.seed_in;
                end
                if (bus.start) begin
                    state_d = S_RUN;
                    count_d = '0;
                    mode_d  = bus.mode;
                end
            end
            S_RUN: begin
                advance = mode_r ? bus.data_valid : 1'b1;
                if (advance) begin
                    if (mode_r) begin
                        q_d = shifted ^ bus.data_in;
                    end else begin
`ifdef BIST_LFSR_LOCKUP_RECOVER_EN
                        if (q_r == '0) begin
                            q_d      = SEED;
                            lockup_d = 1'b1;
                        end else begin
                            q_d = shifted;
                        end
`else
                        q_d = shifted;
`endif
                    end
                    count_d = count_r + 1'b1;
                    if (count_d == LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.q     = q_r;
    assign bus.count = count_r;
    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
`ifdef BIST_LFSR_LOCKUP_RECOVER_EN
    assign bus.lockup = lockup_r;
`else
    assign bus.lockup = 1'b0;
`endif
endmodule

// File: tb/tb_bist_lfsr_misr.sv
// Directed self-checking bench for bist_lfsr_misr: a default instance and a
// short instance (NUM_PATTERNS=4) sharing clock and reset.
module tb_bist_lfsr_misr;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    bist_lfsr_misr_if #(.WIDTH(8), .NUM_PATTERNS(255)) bus  ();
    bist_lfsr_misr_if #(.WIDTH(8), .NUM_PATTERNS(4))   bus4 ();

    bist_lfsr_misr #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .NUM_PATTERNS(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bist_lfsr_misr #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .NUM_PATTERNS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.q !== 8'h01) $display("FAIL reset_q got=%h exp=01", bus.q); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else passed++;
        total++; if (bus.count !== 8'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else passed++;
        total++; if (bus.lockup !== 1'b0) $display("FAIL reset_lockup got=%b exp=0", bus.lockup); else passed++;
        total++; if (bus4.q !== 8'h01) $display("FAIL reset_q4 got=%h exp=01", bus4.q); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_prpg_full();
        logic [7:0] exp_q [4];
        int         early_done;
        exp_q[0] = 8'h02; exp_q[1] = 8'h04; exp_q[2] = 8'h08; exp_q[3] = 8'h11;
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) $display("FAIL prpg_busy got=%b exp=1", bus.busy); else passed++;
        total++; if (bus.q !== 8'h01) $display("FAIL prpg_start_q got=%h exp=01", bus.q); else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus.q !== exp_q[i]) $display("FAIL prpg_seq%0d got=%h exp=%h", i, bus.q, exp_q[i]);
            else passed++;
        end
        early_done = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (bus.done === 1'b1) early_done++;
        end
        total++; if (early_done !== 0) $display("FAIL prpg_early_done got=%0d exp=0", early_done); else passed++;
        tick();
        total++; if (bus.done !== 1'b1) $display("FAIL prpg_done got=%b exp=1", bus.done); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL prpg_done_busy got=%b exp=0", bus.busy); else passed++;
        total++; if (bus.count !== 8'd255) $display("FAIL prpg_count got=%0d exp=255", bus.count); else passed++;
        total++; if (bus.q !== 8'h01) $display("FAIL prpg_period got=%h exp=01", bus.q); else passed++;
        tick();
        total++; if (bus.done !== 1'b0) $display("FAIL prpg_done_width got=%b exp=0", bus.done); else passed++;
        tick();
        total++; if (bus.q !== 8'h01) $display("FAIL prpg_idle_hold_q got=%h exp=01", bus.q); else passed++;
        total++; if (bus.count !== 8'd255) $display("FAIL prpg_idle_hold_count got=%0d exp=255", bus.count); else passed++;
    endtask

    task automatic test_misr();
        bus.seed_load = 1'b1;
        bus.seed_in   = 8'h00;
        tick();
        bus.seed_load = 1'b0;
        total++; if (bus.q !== 8'h00) $display("FAIL misr_seed got=%h exp=00", bus.q); else passed++;
        bus.mode  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        total++; if (bus.count !== 8'd0) $display("FAIL misr_count0 got=%0d exp=0", bus.count); else passed++;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'hA5;
        tick();
        total++; if (bus.q !== 8'hA5) $display("FAIL misr_q1 got=%h exp=a5", bus.q); else passed++;
        bus.data_valid = 1'b0;
        bus.data_in    = 8'hFF;
        tick();
        tick();
        total++; if (bus.q !== 8'hA5) $display("FAIL misr_hold_q got=%h exp=a5", bus.q); else passed++;
        total++; if (bus.count !== 8'd1) $display("FAIL misr_hold_count got=%0d exp=1", bus.count); else passed++;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h3C;
        tick();
        bus.data_valid = 1'b0;
        total++; if (bus.q !== 8'h76) $display("FAIL misr_q2 got=%h exp=76", bus.q); else passed++;
        total++; if (bus.count !== 8'd2) $display("FAIL misr_count2 got=%0d exp=2", bus.count); else passed++;
        total++; if (bus.busy !== 1'b1) $display("FAIL misr_busy got=%b exp=1", bus.busy); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.q !== 8'h01) $display("FAIL misr_abort_q got=%h exp=01", bus.q); else passed++;
    endtask

    task automatic test_short_run();
        int         busy_cycles;
        int         done_cycles;
        logic [7:0] q_at_done;
        logic [2:0] count_at_done;
        busy_cycles   = 0;
        done_cycles   = 0;
        q_at_done     = 8'hxx;
        count_at_done = 3'bxxx;
        bus4.mode  = 1'b0;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus4.busy === 1'b1) busy_cycles++;
            if (bus4.done === 1'b1) begin
                done_cycles++;
                q_at_done     = bus4.q;
                count_at_done = bus4.count;
            end
            if (i == 2) begin
                bus4.start     = 1'b1;
                bus4.mode      = 1'b1;
                bus4.seed_load = 1'b1;
                bus4.seed_in   = 8'hAA;
            end
            if (i == 3) begin
                bus4.start     = 1'b0;
                bus4.mode      = 1'b0;
                bus4.seed_load = 1'b0;
            end
            tick();
        end
        total++; if (busy_cycles !== 4) $display("FAIL short_busy_cycles got=%0d exp=4", busy_cycles); else passed++;
        total++; if (done_cycles !== 1) $display("FAIL short_done_cycles got=%0d exp=1", done_cycles); else passed++;
        total++; if (q_at_done !== 8'h11) $display("FAIL short_final_q got=%h exp=11", q_at_done); else passed++;
        total++; if (count_at_done !== 3'd4) $display("FAIL short_count got=%0d exp=4", count_at_done); else passed++;
        total++; if (bus4.q !== 8'h11) $display("FAIL short_idle_q got=%h exp=11", bus4.q); else passed++;
    endtask

    task automatic test_reset_midrun();
        int stray;
        stray = 0;
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total++; if (bus.count !== 8'd10) $display("FAIL midrun_count got=%0d exp=10", bus.count); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.q !== 8'h01) $display("FAIL midrun_q got=%h exp=01", bus.q); else passed++;
        total++; if (bus.count !== 8'd0) $display("FAIL midrun_cnt0 got=%0d exp=0", bus.count); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL midrun_busy got=%b exp=0", bus.busy); else passed++;
        for (int i = 0; i < 5; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) stray++;
            tick();
        end
        total++; if (stray !== 0) $display("FAIL midrun_no_done got=%0d exp=0", stray); else passed++;
    endtask

    task automatic test_lockup();
        bus.seed_load = 1'b1;
        bus.seed_in   = 8'h00;
        bus.mode      = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        bus.start     = 1'b0;
        total++; if (bus.q !== 8'h00) $display("FAIL lockup_seed got=%h exp=00", bus.q); else passed++;
        tick();
`ifdef BIST_LFSR_LOCKUP_RECOVER_EN
        total++; if (bus.q !== 8'h01) $display("FAIL lockup_q got=%h exp=01", bus.q); else passed++;
        total++; if (bus.lockup !== 1'b1) $display("FAIL lockup_flag got=%b exp=1", bus.lockup); else passed++;
        total++; if (bus.count !== 8'd1) $display("FAIL lockup_count got=%0d exp=1", bus.count); else passed++;
        tick();
        total++; if (bus.q !== 8'h02) $display("FAIL lockup_next_q got=%h exp=02", bus.q); else passed++;
        total++; if (bus.lockup !== 1'b1) $display("FAIL lockup_sticky got=%b exp=1", bus.lockup); else passed++;
`else
        total++; if (bus.q !== 8'h00) $display("FAIL lockup_q got=%h exp=00", bus.q); else passed++;
        total++; if (bus.lockup !== 1'b0) $display("FAIL lockup_flag got=%b exp=0", bus.lockup); else passed++;
        total++; if (bus.count !== 8'd1) $display("FAIL lockup_count got=%0d exp=1", bus.count); else passed++;
        tick();
        total++; if (bus.q !== 8'h00) $display("FAIL lockup_next_q got=%h exp=00", bus.q); else passed++;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.lockup !== 1'b0) $display("FAIL lockup_clear got=%b exp=0", bus.lockup); else passed++;
    endtask

    initial begin
        passed          = 0;
        total           = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.mode        = 1'b0;
        bus.seed_load   = 1'b0;
        bus.seed_in     = 8'h00;
        bus.data_in     = 8'h00;
        bus.data_valid  = 1'b0;
        bus4.start      = 1'b0;
        bus4.mode       = 1'b0;
        bus4.seed_load  = 1'b0;
        bus4.seed_in    = 8'h00;
        bus4.data_in    = 8'h00;
        bus4.data_valid = 1'b0;

        test_reset();
        test_prpg_full();
        test_misr();
        test_short_run();
        test_reset_midrun();
        test_lockup();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bist_lfsr_misr.md
BIST_LFSR_MISR -- requirements
Module: bist_lfsr_misr

Interface
REQ-001 Parameter WIDTH, 8, LFSR/MISR register width (>=4).
REQ-002 Parameter TAPS, 8'hB8, feedback tap mask (WIDTH bits).
REQ-003 Parameter SEED, 8'h01, reset and lockup-recovery value (WIDTH bits).
REQ-004 Parameter NUM_PATTERNS, 255, advances per run (>=1); CNT_W = $clog2(NUM_PATTERNS+1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin run; sampled only in IDLE.
REQ-008 mode  input  1  0 = PRPG (pattern generation), 1 = MISR (signature compaction); sampled with start.
REQ-009 seed_load  input  1  load seed_in into q; honoured only in IDLE.
REQ-010 seed_in  input  WIDTH  seed value.
REQ-011 data_in  input  WIDTH  response word for MISR compaction.
REQ-012 data_valid  input  1  data_in qualifier in MISR mode.
REQ-013 q  output  WIDTH  current register state (pattern or signature).
REQ-014 busy  output  1  high while in RUN.
REQ-015 done  output  1  one-cycle pulse at end of run.
REQ-016 count  output  CNT_W  advances completed in current or last run.
REQ-017 lockup  output  1  sticky all-zero-state flag.

Function
REQ-018 fb SHALL be ^(q & TAPS); an advance SHALL set q to {q[WIDTH-2:0], fb}, XORed with data_in in MISR mode.
REQ-019 FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-020 IDLE: start=1 -> RUN, count<=0, mode latched into mode_r; seed_load=1 without start -> q<=seed_in; both high -> seed_in loaded and run starts from seed_in.
REQ-021 RUN, PRPG: q SHALL advance every cycle and count increment by 1.
REQ-022 RUN, MISR: q advances and count increments only in cycles with data_valid=1; otherwise q and count hold.
REQ-023 Advance that makes count reach NUM_PATTERNS SHALL move FSM to DONE on the same edge.
REQ-024 DONE: done=1, busy=0, q and count hold; next cycle -> IDLE unconditionally.
REQ-025 start, seed_load and mode changes during RUN or DONE SHALL be ignored.
REQ-026 q and count SHALL hold in IDLE until next start/seed_load; count never wraps.
REQ-027 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).

Reset
REQ-028 rst=1 at any edge, including mid-run, SHALL force state=IDLE, q=SEED, count=0, busy=0, done=0, lockup=0, mode_r=0.
REQ-029 rst SHALL take priority over start, seed_load and data_valid.

Configuration
REQ-030 Macro BIST_LFSR_LOCKUP_RECOVER_EN defined: PRPG advance with q==0 SHALL load q<=SEED (count still increments) and set lockup=1 until rst.
REQ-031 Macro undefined: all-zero state advances normally (stays 0 in PRPG), lockup tied 0; MISR behaviour identical in both builds.

Verification
REQ-032 rst -> q=8'h01, busy=0, done=0, count=0, lockup=0.
REQ-033 Defaults, start mode=0 -> q sequence 02,04,08,11 on first four RUN cycles; done pulses one cycle after 255th advance, count=255, period check: q returns to 8'h01 after 255 advances.
REQ-034 MISR: seed_load seed_in=8'h00, start mode=1, data_valid with data_in 8'hA5 then 8'h3C -> q=8'hA5 then 8'h76, count=2; data_valid=0 cycles -> q holds.
REQ-035 NUM_PATTERNS=4, PRPG from 8'h01 -> busy high exactly 4 cycles, done high exactly 1 cycle, final q=8'h11; start during RUN ignored.
REQ-036 rst asserted mid-run at count=10 -> next cycle IDLE, q=8'h01, count=0, no done pulse.
REQ-037 seed_load 8'h00, start PRPG -> with BIST_LFSR_LOCKUP_RECOVER_EN q=8'h01, lockup=1 after first advance; without it q stays 8'h00, lockup=0.
